// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port synchronous RAM with 1-cycle read latency.
// Optional instruction anti-starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_ena,
  output logic [3:0]        m_wea,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_dina,
  input  logic [31:0]       m_douta
);

  typedef enum logic [1:0] {StIdle, StRdI, StRdD} state_e;

  state_e      state_q, state_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        guard;

  // Upper address bits are outside the RAM and intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{i_addr[31:ADDR_W], d_addr[31:ADDR_W]};

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_q, starve_d;

  assign guard = (starve_q == CntW'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (!i_req || i_gnt) begin
      starve_d = '0;
    end else if (!guard) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign guard = 1'b0;
`endif

  // Grants are gated by rst_n so nothing reaches the RAM while in reset.
  always_comb begin
    i_gnt  = rst_n & i_req & (~d_req | guard);
    d_gnt  = rst_n & d_req & ~i_gnt;
    m_ena  = i_gnt | d_gnt;
    m_wea  = d_gnt ? d_we : 4'b0000;
    m_addr = d_gnt ? d_addr[ADDR_W-1:0] : i_addr[ADDR_W-1:0];
    m_dina = d_wdata;
  end

  always_comb begin
    state_d = StIdle;
    if (i_gnt) begin
      state_d = StRdI;
    end else if (d_gnt && (d_we == 4'b0000)) begin
      state_d = StRdD;
    end
  end

  // Read data is forwarded straight from the RAM in the response cycle and held afterwards.
  always_comb begin
    i_rdata_d = (state_q == StRdI) ? m_douta : i_rdata_q;
    d_rdata_d = (state_q == StRdD) ? m_douta : d_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_rvalid = (state_q == StRdI);
  assign d_rvalid = (state_q == StRdD);
  assign i_rdata  = i_rdata_d;
  assign d_rdata  = d_rdata_d;

endmodule
